// File: rtl/flexsoc_reset_seq.sv
// Staggered multi-domain reset sequencer: releases active-low domain resets in order
// after power-on or a global request, and handles per-domain soft resets.
module flexsoc_reset_seq #(
  parameter int unsigned NUM_DOMAINS = 4,
  parameter int unsigned HOLD_CYCLES = 15,
  parameter int unsigned STAGE_GAP   = 4
) (
  input  logic                   CLK,
  input  logic                   PORESET,
  input  logic                   GLOBAL_REQ,
  input  logic [NUM_DOMAINS-1:0] DOMAIN_REQ,
  output logic [NUM_DOMAINS-1:0] RESETn,
  output logic                   BUSY,
  output logic [1:0]             CAUSE
);

  typedef enum logic [1:0] {HOLD, STAGE, RUN} state_t;

  localparam logic [15:0] HOLD_LD    = 16'(HOLD_CYCLES);
  localparam logic [7:0]  GAP_LD     = 8'(STAGE_GAP - 1);
  localparam logic [4:0]  LAST_IDX   = 5'(NUM_DOMAINS - 1);
  localparam logic [1:0]  CAUSE_POR  = 2'd0;
  localparam logic [1:0]  CAUSE_GLOB = 2'd1;
  localparam logic [1:0]  CAUSE_DOM  = 2'd2;

  state_t                 state, state_nxt;
  logic [15:0]            hold_cnt, hold_cnt_nxt;
  logic [7:0]             gap_cnt, gap_cnt_nxt;
  logic [4:0]             idx, idx_nxt;
  logic [15:0]            dom_cnt     [NUM_DOMAINS];
  logic [15:0]            dom_cnt_nxt [NUM_DOMAINS];
  logic [NUM_DOMAINS-1:0] dom_act, dom_act_nxt;
  logic [NUM_DOMAINS-1:0] rstn_nxt;
  logic                   busy_nxt;
  logic [1:0]             cause_nxt;

  always_ff @(posedge CLK or posedge PORESET) begin
    if (PORESET) begin
      state    <= HOLD;
      hold_cnt <= HOLD_LD;
      gap_cnt  <= '0;
      idx      <= '0;
      dom_act  <= '0;
      for (int unsigned d = 0; d < NUM_DOMAINS; d++) dom_cnt[d] <= '0;
      RESETn   <= '0;
      BUSY     <= 1'b1;
      CAUSE    <= CAUSE_POR;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      gap_cnt  <= gap_cnt_nxt;
      idx      <= idx_nxt;
      dom_act  <= dom_act_nxt;
      for (int unsigned d = 0; d < NUM_DOMAINS; d++) dom_cnt[d] <= dom_cnt_nxt[d];
      RESETn   <= rstn_nxt;
      BUSY     <= busy_nxt;
      CAUSE    <= cause_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    gap_cnt_nxt  = gap_cnt;
    idx_nxt      = idx;
    dom_act_nxt  = dom_act;
    dom_cnt_nxt  = dom_cnt;
    rstn_nxt     = RESETn;
    busy_nxt     = BUSY;
    cause_nxt    = CAUSE;

    // Global request overrides everything, including same-cycle domain requests.
    if (GLOBAL_REQ) begin
      state_nxt    = HOLD;
      hold_cnt_nxt = HOLD_LD;
      idx_nxt      = '0;
      dom_act_nxt  = '0;
      rstn_nxt     = '0;
      busy_nxt     = 1'b1;
      cause_nxt    = CAUSE_GLOB;
    end else begin
      unique case (state)
        HOLD: begin
          if (hold_cnt == '0) begin
            rstn_nxt[0] = 1'b1;
            if (NUM_DOMAINS == 1) begin
              state_nxt = RUN;
              busy_nxt  = 1'b0;
            end else begin
              state_nxt   = STAGE;
              gap_cnt_nxt = GAP_LD;
              idx_nxt     = 5'd1;
            end
          end else begin
            hold_cnt_nxt = hold_cnt - 16'd1;
          end
        end
        STAGE: begin
          if (gap_cnt == '0) begin
            for (int unsigned d = 0; d < NUM_DOMAINS; d++)
              if (idx == 5'(d)) rstn_nxt[d] = 1'b1;
            gap_cnt_nxt = GAP_LD;
            if (idx == LAST_IDX) begin
              state_nxt = RUN;
              busy_nxt  = 1'b0;
            end else begin
              idx_nxt = idx + 5'd1;
            end
          end else begin
            gap_cnt_nxt = gap_cnt - 8'd1;
          end
        end
        RUN: begin
          for (int unsigned d = 0; d < NUM_DOMAINS; d++) begin
            if (DOMAIN_REQ[d]) begin
              rstn_nxt[d]    = 1'b0;
              dom_cnt_nxt[d] = HOLD_LD;
              dom_act_nxt[d] = 1'b1;
              cause_nxt      = CAUSE_DOM;
            end else if (dom_act[d]) begin
              if (dom_cnt[d] == '0) begin
                rstn_nxt[d]    = 1'b1;
                dom_act_nxt[d] = 1'b0;
              end else begin
                dom_cnt_nxt[d] = dom_cnt[d] - 16'd1;
              end
            end
          end
        end
        default: state_nxt = HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_flexsoc_reset_seq.sv
// Scoreboard bench for flexsoc_reset_seq: default build plus a 1-domain, 1-cycle-hold build.
module tb_flexsoc_reset_seq;

  localparam int unsigned H = 15;
  localparam int unsigned G = 4;
  localparam int unsigned N = 4;

  typedef struct {
    int unsigned cyc;
    int unsigned which;
    logic [3:0]  rstn;
    logic        busy;
    logic [1:0]  cause;
  } exp_t;

  logic       CLK = 1'b0;
  logic       PORESET = 1'b0;
  logic       GLOBAL_REQ = 1'b0;
  logic [3:0] DOMAIN_REQ = '0;
  logic [3:0] RESETn0;
  logic       BUSY0;
  logic [1:0] CAUSE0;
  logic [0:0] RESETn1;
  logic       BUSY1;
  logic [1:0] CAUSE1;

  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  exp_t        sb[$];

  flexsoc_reset_seq #(.NUM_DOMAINS(4), .HOLD_CYCLES(15), .STAGE_GAP(4)) dut0 (
    .CLK(CLK), .PORESET(PORESET), .GLOBAL_REQ(GLOBAL_REQ), .DOMAIN_REQ(DOMAIN_REQ),
    .RESETn(RESETn0), .BUSY(BUSY0), .CAUSE(CAUSE0)
  );

  flexsoc_reset_seq #(.NUM_DOMAINS(1), .HOLD_CYCLES(1), .STAGE_GAP(4)) dut1 (
    .CLK(CLK), .PORESET(PORESET), .GLOBAL_REQ(1'b0), .DOMAIN_REQ(1'b0),
    .RESETn(RESETn1), .BUSY(BUSY1), .CAUSE(CAUSE1)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic push(input int unsigned c, input int unsigned w, input logic [3:0] r,
                      input logic b, input logic [1:0] ca);
    exp_t e;
    e.cyc = c; e.which = w; e.rstn = r; e.busy = b; e.cause = ca;
    sb.push_back(e);
  endtask

  // Expected outputs for a full release sequence whose edge 1 is cycle base+1.
  task automatic push_seq(input int unsigned base, input logic [1:0] ca,
                          input int unsigned e_from, input int unsigned e_to);
    logic [3:0] r;
    for (int unsigned e = e_from; e <= e_to; e++) begin
      r = '0;
      for (int unsigned k = 0; k < N; k++)
        if (e >= H + 1 + k * G) r[k] = 1'b1;
      push(base + e, 0, r, e < H + 1 + (N - 1) * G, ca);
    end
  endtask

  task automatic wait_cyc(input int unsigned c);
    while (cyc < c) @(negedge CLK);
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  always @(negedge CLK) begin
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        if (sb[i].which == 0) begin
          check($sformatf("d0_rstn c%0d", cyc), 32'(RESETn0), 32'(sb[i].rstn));
          check($sformatf("d0_busy c%0d", cyc), 32'(BUSY0), 32'(sb[i].busy));
          check($sformatf("d0_cause c%0d", cyc), 32'(CAUSE0), 32'(sb[i].cause));
        end else begin
          check($sformatf("d1_rstn c%0d", cyc), 32'(RESETn1), 32'(sb[i].rstn[0]));
          check($sformatf("d1_busy c%0d", cyc), 32'(BUSY1), 32'(sb[i].busy));
          check($sformatf("d1_cause c%0d", cyc), 32'(CAUSE1), 32'(sb[i].cause));
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    int unsigned s;

    // Power-on reset, 3 cycles.
    #2 PORESET = 1'b1;
    #1;
    check("por_rstn", 32'(RESETn0), 32'h0);
    check("por_busy", 32'(BUSY0), 32'h1);
    check("por_cause", 32'(CAUSE0), 32'h0);
    check("por1_rstn", 32'(RESETn1), 32'h0);
    repeat (3) @(negedge CLK);
    PORESET = 1'b0;
    s = cyc;
    push_seq(s, 2'd0, 1, 30);
    push(s + 1, 1, 4'b0000, 1'b1, 2'd0);
    push(s + 2, 1, 4'b0001, 1'b0, 2'd0);
    push(s + 3, 1, 4'b0001, 1'b0, 2'd0);
    drain();

    // Single-cycle soft reset of domain 3.
    @(negedge CLK);
    DOMAIN_REQ = 4'b1000;
    s = cyc + 1;
    for (int unsigned c = s; c <= s + 17; c++)
      push(c, 0, (c < s + 16) ? 4'b0111 : 4'b1111, 1'b0, 2'd2);
    @(negedge CLK);
    DOMAIN_REQ = '0;
    drain();

    // Independent domains: bit 0 held three cycles, bit 2 pulsed once.
    @(negedge CLK);
    DOMAIN_REQ = 4'b0001;
    s = cyc + 1;
    for (int unsigned c = s; c <= s + 19; c++)
      push(c, 0, {1'b1, !(c >= s + 1 && c < s + 17), 1'b1, !(c < s + 18)}, 1'b0, 2'd2);
    @(negedge CLK);
    DOMAIN_REQ = 4'b0101;
    @(negedge CLK);
    DOMAIN_REQ = 4'b0001;
    @(negedge CLK);
    DOMAIN_REQ = '0;
    drain();

    // Global request together with a domain request, then a domain request during STAGE.
    @(negedge CLK);
    GLOBAL_REQ = 1'b1;
    DOMAIN_REQ = 4'b0010;
    s = cyc + 1;
    push_seq(s, 2'd1, 0, 30);
    @(negedge CLK);
    GLOBAL_REQ = 1'b0;
    DOMAIN_REQ = '0;
    wait_cyc(s + 20);
    DOMAIN_REQ = 4'b0100;
    @(negedge CLK);
    DOMAIN_REQ = '0;
    drain();

    // Power-on reset arriving mid-sequence, after edge 22.
    @(negedge CLK);
    GLOBAL_REQ = 1'b1;
    s = cyc + 1;
    push_seq(s, 2'd1, 0, 22);
    @(negedge CLK);
    GLOBAL_REQ = 1'b0;
    wait_cyc(s + 22);
    #2 PORESET = 1'b1;
    #1;
    check("midpor_rstn", 32'(RESETn0), 32'h0);
    check("midpor_busy", 32'(BUSY0), 32'h1);
    check("midpor_cause", 32'(CAUSE0), 32'h0);
    repeat (2) @(negedge CLK);
    PORESET = 1'b0;
    s = cyc;
    push_seq(s, 2'd0, 1, 30);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
